// File: rtl/axi4_lite_lstm_weight_bank.sv
// LSTM weight/bias banks behind an AXI4-Lite slave, with a read-only engine port.
// Optional macro LSTM_AXI_RD_PIPE_EN adds an output register stage to both read paths.
module axi4_lite_lstm_weight_bank #(
    parameter int AXI_WIDTH  = 32,
    parameter int AXI_DEPTH  = 512,
    parameter int LAYERS     = 4,
    parameter int DATA_WIDTH = 16,
    localparam int WEIGHTS   = 4,
    localparam int DW        = $clog2(AXI_DEPTH),
    localparam int BW        = $clog2(LAYERS * WEIGHTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXI_WIDTH-1:0]   awaddr,
    input  logic [2:0]             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [AXI_WIDTH-1:0]   wdata,
    input  logic [AXI_WIDTH/8-1:0] wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [AXI_WIDTH-1:0]   araddr,
    input  logic [2:0]             arprot,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [AXI_WIDTH-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    input  logic                   eng_rd_en,
    input  logic [BW-1:0]          eng_bank,
    input  logic [DW-1:0]          eng_addr,
    output logic [DATA_WIDTH-1:0]  eng_rdata
);

    localparam int NB = LAYERS * WEIGHTS;
    localparam int IW = BW + DW;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_MEM  = 2'd1;
`ifdef LSTM_AXI_RD_PIPE_EN
    localparam logic [1:0] R_PIPE = 2'd2;
`endif
    localparam logic [1:0] R_DATA = 2'd3;

    function automatic logic addr_bad(input logic [AXI_WIDTH-1:0] a);
        logic [AXI_WIDTH-1:0] hi;
        hi = a >> (IW + 2);
        return (hi != '0) || ({1'b0, a[IW+1:DW+2]} >= (BW+1)'(NB));
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:(1<<IW)-1];

    logic [0:0]             w_state;
    logic                   aw_held;
    logic                   w_held;
    logic [AXI_WIDTH-1:0]   aw_q;
    logic [AXI_WIDTH-1:0]   w_q;
    logic [AXI_WIDTH/8-1:0] s_q;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   commit;
    logic [AXI_WIDTH-1:0]   aw_a;
    logic [AXI_WIDTH-1:0]   w_d;
    logic [AXI_WIDTH/8-1:0] w_s;
    logic                   w_bad;
    logic [IW-1:0]          w_idx;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [DATA_WIDTH-1:0]  w_mask;

    logic [1:0]             r_state;
    logic [AXI_WIDTH-1:0]   ar_q;
    logic                   ar_bad;
    logic [DATA_WIDTH-1:0]  mem_q;
    logic [DATA_WIDTH-1:0]  rd_word;

    logic                   eng_hit;
    logic                   eng_ok;
    logic [DATA_WIDTH-1:0]  eng_q;
`ifdef LSTM_AXI_RD_PIPE_EN
    logic                   eng_pv;
    logic                   eng_pok;
    logic [DATA_WIDTH-1:0]  eng_p;
`endif

    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, w_d, w_s, aw_a[1:0], ar_q[1:0]};

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign commit = (w_state == W_IDLE)
                  && (aw_held || aw_hs) && (w_held || w_hs);
    assign aw_a   = aw_held ? aw_q : awaddr;
    assign w_d    = w_held ? w_q : wdata;
    assign w_s    = w_held ? s_q : wstrb;
    assign w_bad  = addr_bad(aw_a);
    assign w_idx  = aw_a[IW+1:2];
    assign w_data = w_d[DATA_WIDTH-1:0];

    // Strobe lanes only cover bits that physically exist in the stored word.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_mask[i] = w_s[i/8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_q    <= '0;
            w_q     <= '0;
            s_q     <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
        end else if (w_state == W_IDLE) begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                awready <= 1'b0;
                wready  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= w_bad ? 2'b10 : 2'b00;
                w_state <= W_RESP;
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_q    <= awaddr;
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                    w_q    <= wdata;
                    s_q    <= wstrb;
                end
                awready <= !(aw_held || aw_hs);
                wready  <= !(w_held || w_hs);
            end
        end else if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            ar_q    <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        ar_q    <= araddr;
                        arready <= 1'b0;
                        r_state <= R_MEM;
                    end else begin
                        arready <= 1'b1;
                    end
                end
`ifdef LSTM_AXI_RD_PIPE_EN
                R_MEM: r_state <= R_PIPE;
                R_PIPE: begin
                    rvalid  <= 1'b1;
                    r_state <= R_DATA;
                end
`else
                R_MEM: begin
                    rvalid  <= 1'b1;
                    r_state <= R_DATA;
                end
`endif
                R_DATA: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign ar_bad = addr_bad(ar_q);
    assign rresp  = (rvalid && ar_bad) ? 2'b10 : 2'b00;
    assign rdata  = (rvalid && !ar_bad)
                  ? AXI_WIDTH'($signed(rd_word)) : '0;

    assign eng_hit = {1'b0, eng_bank} < (BW+1)'(NB);

    // Non-blocking reads alongside the commit give read-first behaviour.
    always_ff @(posedge clk) begin
        if (commit && !w_bad) begin
            mem[w_idx] <= (mem[w_idx] & ~w_mask) | (w_data & w_mask);
        end
        if (r_state == R_MEM) begin
            mem_q <= mem[ar_q[IW+1:2]];
        end
`ifdef LSTM_AXI_RD_PIPE_EN
        if (r_state == R_PIPE) begin
            rd_word <= mem_q;
        end
        if (eng_rd_en) begin
            eng_p <= mem[{eng_bank, eng_addr}];
        end
        if (eng_pv) begin
            eng_q <= eng_p;
        end
`else
        if (eng_rd_en) begin
            eng_q <= mem[{eng_bank, eng_addr}];
        end
`endif
    end

`ifndef LSTM_AXI_RD_PIPE_EN
    assign rd_word = mem_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_ok  <= 1'b0;
`ifdef LSTM_AXI_RD_PIPE_EN
            eng_pv  <= 1'b0;
            eng_pok <= 1'b0;
`endif
        end else begin
`ifdef LSTM_AXI_RD_PIPE_EN
            eng_pv <= eng_rd_en;
            if (eng_rd_en) eng_pok <= eng_hit;
            if (eng_pv) eng_ok <= eng_pok;
`else
            if (eng_rd_en) eng_ok <= eng_hit;
`endif
        end
    end

    assign eng_rdata = eng_ok ? eng_q : '0;

endmodule

// File: tb/tb_axi4_lite_lstm_weight_bank.sv
// Randomised self-checking bench for axi4_lite_lstm_weight_bank.
// Expected values come from a word-indexed array model of the weight banks.
module tb_axi4_lite_lstm_weight_bank;

`ifdef LSTM_AXI_RD_PIPE_EN
    localparam int RD_LAT  = 3;
    localparam int ENG_LAT = 2;
`else
    localparam int RD_LAT  = 2;
    localparam int ENG_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        eng_rd_en = 1'b0;
    logic [3:0]  eng_bank = '0;
    logic [8:0]  eng_addr = '0;
    logic [15:0] eng_rdata;

    int errors = 0;
    int checks = 0;
    logic [15:0] mdl [int];

    axi4_lite_lstm_weight_bank dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .eng_rd_en(eng_rd_en), .eng_bank(eng_bank), .eng_addr(eng_addr),
        .eng_rdata(eng_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 512 words per bank, 4 bytes per word: bank starts every 2 KiB.
    function automatic logic [31:0] adr(input int b, input int w);
        return 32'(b * 2048 + w * 4);
    endfunction

    function automatic int key_of(input logic [31:0] a);
        return int'(a[14:2]);
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic void mdl_write(input int k, input logic [31:0] d,
                                      input logic [3:0] s);
        logic [15:0] v;
        v = mdl.exists(k) ? mdl[k] : 16'h0;
        if (s[0]) v[7:0] = d[7:0];
        if (s[1]) v[15:8] = d[15:8];
        mdl[k] = v;
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp,
                             output int lat);
        bit ad = 0;
        bit wd = 0;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        while (!(ad && wd) && n < 20) begin
            bit ah;
            bit wh;
            ah = awvalid && awready;
            wh = wvalid && wready;
            step();
            n++;
            if (ah) begin ad = 1; awvalid = 1'b0; end
            if (wh) begin wd = 1; wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        while (!bvalid && lat < 20) begin step(); lat++; end
        if (!bvalid) lat = -1;
        resp = bresp;
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output int lat);
        int n = 0;
        araddr = a;
        arvalid = 1'b1;
        while (!arready && n < 20) begin step(); n++; end
        step();
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 20) begin step(); lat++; end
        if (!rvalid) lat = -1;
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if ({bresp, rresp, rdata, eng_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h/%h want zeros",
                     bresp, rresp, rdata, eng_rdata);
        end
        rst = 1'b0;
        checks++;
        if (awready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: awready got %b want 0", awready);
        end
        step();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready_rise: got %b want 111",
                     {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        logic [1:0]  r;
        logic [31:0] d;
        int lat;
        axi_write(adr(5, 3), 32'h0000_8001, 4'hF, r, lat);
        mdl_write(5 * 512 + 3, 32'h0000_8001, 4'hF);
        checks++;
        if (r !== 2'b00 || lat != 1) begin
            errors++;
            $display("FAIL basic_write: resp %b lat %0d want 00 lat 1", r, lat);
        end
        axi_read(adr(5, 3), d, r, lat);
        checks++;
        if (d !== 32'hFFFF_8001 || r !== 2'b00) begin
            errors++;
            $display("FAIL basic_read: got %h/%b want ffff8001/00", d, r);
        end
        checks++;
        if (lat != RD_LAT) begin
            errors++;
            $display("FAIL basic_read_lat: got %0d want %0d", lat, RD_LAT);
        end
    endtask

    task automatic test_split();
        logic [1:0]  r;
        logic [31:0] d;
        int lat;
        for (int m = 0; m < 2; m++) begin
            logic [31:0] a;
            logic [31:0] v;
            a = adr(2 + m, 7 + m);
            v = $urandom;
            awaddr = a; wdata = v; wstrb = 4'hF; bready = 1'b0;
            if (m == 0) awvalid = 1'b1; else wvalid = 1'b1;
            step();
            awvalid = 1'b0; wvalid = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                checks++;
                if ((m == 0 ? awready : wready) !== 1'b0 || bvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL split_hold m%0d c%0d: ready %b bvalid %b want 0 0",
                             m, c, m == 0 ? awready : wready, bvalid);
                end
                if (c == 4) begin
                    if (m == 0) wvalid = 1'b1; else awvalid = 1'b1;
                end
                step();
            end
            awvalid = 1'b0; wvalid = 1'b0;
            mdl_write(key_of(a), v, 4'hF);
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00) begin
                errors++;
                $display("FAIL split_bvalid m%0d: got %b/%b want 1/00", m, bvalid, bresp);
            end
            bready = 1'b1;
            step();
            bready = 1'b0;
            axi_read(a, d, r, lat);
            checks++;
            if (d !== sx(mdl[key_of(a)])) begin
                errors++;
                $display("FAIL split_read m%0d: got %h want %h", m, d, sx(mdl[key_of(a)]));
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r;
        logic [31:0] d;
        int lat;
        axi_write(adr(0, 0), 32'h1234, 4'hF, r, lat);
        mdl_write(0, 32'h1234, 4'hF);
        axi_write(adr(0, 0), 32'hFF, 4'b0001, r, lat);
        mdl_write(0, 32'hFF, 4'b0001);
        axi_read(adr(0, 0), d, r, lat);
        checks++;
        if (d !== 32'h0000_12FF) begin
            errors++;
            $display("FAIL strobe_low: got %h want 000012ff", d);
        end
        axi_write(adr(0, 0), 32'hABCD_ABCD, 4'b1100, r, lat);
        axi_read(adr(0, 0), d, r, lat);
        checks++;
        if (d !== 32'h0000_12FF || r !== 2'b00) begin
            errors++;
            $display("FAIL strobe_high: got %h/%b want 000012ff/00", d, r);
        end
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            logic [31:0] v0;
            logic [31:0] v1;
            logic [3:0]  s;
            a = $urandom & 32'h0000_7FFF;
            v0 = $urandom; v1 = $urandom; s = 4'($urandom);
            axi_write(a, v0, 4'hF, r, lat);
            mdl_write(key_of(a), v0, 4'hF);
            axi_write(a, v1, s, r, lat);
            mdl_write(key_of(a), v1, s);
            axi_read(a, d, r, lat);
            checks++;
            if (d !== sx(mdl[key_of(a)]) || r !== 2'b00) begin
                errors++;
                $display("FAIL strobe_rand %0d a=%h s=%b: got %h/%b want %h/00",
                         i, a, s, d, r, sx(mdl[key_of(a)]));
            end
        end
    endtask

    task automatic test_error();
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] ea;
        int lat;
        axi_write(adr(0, 0), 32'h5A5A, 4'hF, r, lat);
        mdl_write(0, 32'h5A5A, 4'hF);
        axi_write(32'h0000_8000, 32'h7777, 4'hF, r, lat);
        checks++;
        if (r !== 2'b10 || lat != 1) begin
            errors++;
            $display("FAIL err_write: resp %b lat %0d want 10 lat 1", r, lat);
        end
        axi_read(32'h0000_8000, d, r, lat);
        checks++;
        if (d !== 32'h0 || r !== 2'b10 || lat != RD_LAT) begin
            errors++;
            $display("FAIL err_read: got %h/%b lat %0d want 0/10 lat %0d",
                     d, r, lat, RD_LAT);
        end
        ea = (32'h1 << $urandom_range(31, 15)) | ($urandom & 32'h7FFF);
        axi_write(ea, 32'h1111, 4'hF, r, lat);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL err_write_hi a=%h: resp %b want 10", ea, r);
        end
        axi_read(adr(0, 0), d, r, lat);
        checks++;
        if (d !== sx(mdl[0])) begin
            errors++;
            $display("FAIL err_nochange: got %h want %h", d, sx(mdl[0]));
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] a2;
        logic [31:0] v;
        logic [31:0] d;
        logic [1:0]  r;
        int lat;
        int n;
        a = adr(7, 100); a2 = adr(8, 200); v = $urandom;
        awaddr = a; wdata = v; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        mdl_write(key_of(a), v, 4'hF);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL stall_same_cycle: got %b/%b want 1/00", bvalid, bresp);
        end
        awaddr = a2; awvalid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) begin
                errors++;
                $display("FAIL stall_b c%0d: bvalid %b bresp %b awready %b want 1 00 0",
                         c, bvalid, bresp, awready);
            end
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: awready %b bvalid %b want 1 0", awready, bvalid);
        end
        wdata = 32'h0000_0BAD; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        mdl_write(key_of(a2), 32'h0BAD, 4'hF);
        bready = 1'b1;
        step();
        bready = 1'b0;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin step(); n++; end
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== sx(mdl[key_of(a)])) begin
                errors++;
                $display("FAIL stall_r c%0d: rvalid %b rresp %b rdata %h want 1 00 %h",
                         c, rvalid, rresp, rdata, sx(mdl[key_of(a)]));
            end
            step();
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        axi_read(a2, d, r, lat);
        checks++;
        if (d !== sx(mdl[key_of(a2)])) begin
            errors++;
            $display("FAIL stall_second_aw: got %h want %h", d, sx(mdl[key_of(a2)]));
        end
    endtask

    task automatic test_engine();
        logic [15:0] old;
        logic [15:0] nv;
        int k;
        k = 5 * 512 + 3;
        eng_bank = 4'd5; eng_addr = 9'd3; eng_rd_en = 1'b1;
        step();
        eng_rd_en = 1'b0;
        for (int i = 1; i < ENG_LAT; i++) step();
        checks++;
        if (eng_rdata !== mdl[k]) begin
            errors++;
            $display("FAIL eng_read: got %h want %h", eng_rdata, mdl[k]);
        end
        eng_addr = 9'd4;
        step(); step(); step();
        checks++;
        if (eng_rdata !== mdl[k]) begin
            errors++;
            $display("FAIL eng_hold: got %h want %h", eng_rdata, mdl[k]);
        end
        old = mdl[k];
        nv = ~old;
        awaddr = adr(5, 3); wdata = {16'h0, nv}; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        eng_addr = 9'd3; eng_rd_en = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; eng_rd_en = 1'b0;
        mdl_write(k, {16'h0, nv}, 4'hF);
        for (int i = 1; i < ENG_LAT; i++) step();
        checks++;
        if (eng_rdata !== old) begin
            errors++;
            $display("FAIL eng_read_first: got %h want %h", eng_rdata, old);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        eng_rd_en = 1'b1;
        step();
        eng_rd_en = 1'b0;
        for (int i = 1; i < ENG_LAT; i++) step();
        checks++;
        if (eng_rdata !== nv) begin
            errors++;
            $display("FAIL eng_new: got %h want %h", eng_rdata, nv);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  r;
        int lat;
        int n;
        a = adr(9, 33);
        awaddr = a; wdata = 32'h0000_4321; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        mdl_write(key_of(a), 32'h4321, 4'hF);
        rst = 1'b1;
        #1;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_bvalid: bvalid %b awready %b want 0 0", bvalid, awready);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_awready: got %b want 1", awready);
        end
        awaddr = a; awvalid = 1'b1;
        araddr = a; arvalid = 1'b1;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        rst = 1'b1;
        #1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_rvalid: rvalid %b rdata %h want 0 0", rvalid, rdata);
        end
        step();
        rst = 1'b0;
        step();
        wdata = 32'h0000_0EEE; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        step();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_aw_dropped: bvalid %b want 0", bvalid);
        end
        axi_read(a, d, r, lat);
        checks++;
        if (d !== sx(mdl[key_of(a)])) begin
            errors++;
            $display("FAIL rstmid_mem: got %h want %h", d, sx(mdl[key_of(a)]));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_split();
        test_strobe();
        test_error();
        test_stall();
        test_engine();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
